// File: rtl/rs232_tx_fifo.sv
// RS232 8N1 transmitter with a small byte FIFO in front of it.
// Byte strobes are queued so back-to-back writes survive while a frame is on the line;
// the serialiser drains the FIFO one frame at a time, LSB first.
module rs232_tx_fifo #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] RS_DATAIN,
    input  logic       RS_TRG_WRITE,
    output logic       TXD,
    output logic       RS_BUSY,
    output logic       FIFO_FULL,
    output logic       OVERFLOW,
    output logic       TX_DONE
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned BW    = $clog2(BAUD_DIV);

    localparam logic [BW-1:0]      BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               full;
    logic               push;
    logic               pop;

    // Serialiser state
    state_e             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               baud_end;

    // Registered line outputs
    logic               txd_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;

    // Fullness is judged on the count at the start of the cycle, so a same-cycle pop
    // never rescues a write that arrives while the FIFO is full.
    assign full     = (count_q == CNT_FULL);
    assign push     = RS_TRG_WRITE && !full;
    assign baud_end = (baud_q == BAUD_LAST);

    // FIFO data array; contents need no reset because pointers gate every read
    always_ff @(posedge CLK_50MHZ) begin
        if (push) begin
            mem[wr_ptr_q] <= RS_DATAIN;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser state register
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Serialiser next-state: each bit period is exactly BAUD_DIV clocks
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line outputs registered from the current state, so TXD, TX_DONE and RS_BUSY
    // all lag the state by one clock and stay mutually aligned.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StStart: txd_q <= 1'b0;
                StData:  txd_q <= shreg_q[0];
                default: txd_q <= 1'b1;
            endcase
            busy_q <= (state_q != StIdle) || (count_q != '0);
            done_q <= (state_q == StStop) && baud_end;
        end
    end

    // Sticky overflow: any write that meets a full FIFO
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (RS_TRG_WRITE && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign TXD       = txd_q;
    assign RS_BUSY   = busy_q;
    assign FIFO_FULL = full;
    assign OVERFLOW  = ovf_q;
    assign TX_DONE   = done_q;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Self-checking bench for rs232_tx_fifo: a fast instance (BAUD_DIV=4) checked cycle by
// cycle against a frame-level reference model, plus a slow instance (BAUD_DIV=434).
module tb_rs232_tx_fifo;

    localparam int B  = 4;
    localparam int BS = 434;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       wr;
    logic       txd, busy, full, ovf, done;

    logic [7:0] s_data;
    logic       s_wr;
    logic       s_txd, s_busy, s_full, s_ovf, s_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    rs232_tx_fifo #(.BAUD_DIV(B), .FIFO_AW(2)) dut (
        .CLK_50MHZ    (clk),
        .RST          (rst_n),
        .RS_DATAIN    (data),
        .RS_TRG_WRITE (wr),
        .TXD          (txd),
        .RS_BUSY      (busy),
        .FIFO_FULL    (full),
        .OVERFLOW     (ovf),
        .TX_DONE      (done)
    );

    rs232_tx_fifo #(.BAUD_DIV(BS), .FIFO_AW(2)) dut_slow (
        .CLK_50MHZ    (clk),
        .RST          (rst_n),
        .RS_DATAIN    (s_data),
        .RS_TRG_WRITE (s_wr),
        .TXD          (s_txd),
        .RS_BUSY      (s_busy),
        .FIFO_FULL    (s_full),
        .OVERFLOW     (s_ovf),
        .TX_DONE      (s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a byte queue plus "edges since the last pop" for the frame.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_p;
    logic [7:0] m_cur;
    bit         m_ovf;
    bit         e_txd, e_busy, e_full, e_ovf, e_done;

    // Line level of frame bit i: start, 8 data bits LSB first, stop
    function automatic bit frame_bit(logic [7:0] b, int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_active = 1'b0;
        m_p      = 0;
        m_cur    = '0;
        m_ovf    = 1'b0;
        e_txd    = 1'b1;
        e_busy   = 1'b0;
        e_full   = 1'b0;
        e_ovf    = 1'b0;
        e_done   = 1'b0;
    endfunction

    // One clock edge of the model; outputs after the edge depend on pre-edge state
    function automatic void model_step(bit w, logic [7:0] d);
        int pre_size;
        bit pre_run;
        pre_size = mq.size();
        pre_run  = m_active && (m_p < 10 * B);
        e_busy   = pre_run || (pre_size != 0);
        e_txd    = pre_run ? frame_bit(m_cur, m_p / B) : 1'b1;
        e_done   = m_active && (m_p == 10 * B - 1);
        if (!pre_run && pre_size > 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_p      = 0;
        end else if (m_active && m_p < 10 * B) begin
            m_p++;
        end
        if (w) begin
            if (pre_size == 4) m_ovf = 1'b1;
            else mq.push_back(d);
        end
        e_ovf  = m_ovf;
        e_full = (mq.size() == 4);
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
        end
    endtask

    // Drive inputs for one cycle, advance model and DUT, compare all outputs
    task automatic cyc(bit w, logic [7:0] d);
        wr   = w;
        data = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(w, d);
        #1;
        cyc_n++;
        check("txd", int'(txd), int'(e_txd));
        check("busy", int'(busy), int'(e_busy));
        check("full", int'(full), int'(e_full));
        check("overflow", int'(ovf), int'(e_ovf));
        check("tx_done", int'(done), int'(e_done));
        wr   = 1'b0;
        data = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         txd;
        bit         busy;
        bit         full;
        bit         ovf;
    } vec_t;

    vec_t vec[7];

    initial begin
        int first_low, done_at, busy_fall, n_done, good, wait_n;
        bit saw_full;

        // Six consecutive writes from idle: fifth fills the FIFO, sixth is dropped
        vec[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[5] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1};
        vec[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};

        wr     = 1'b0;
        data   = 8'h00;
        s_wr   = 1'b0;
        s_data = 8'h00;
        rst_n  = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("reset_txd", int'(txd), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_full", int'(full), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_done", int'(done), 0);
        do_reset();

        // Single byte 0x55: latency, frame length, busy fall
        cyc(1'b1, 8'h55);
        first_low = -1; done_at = -1; busy_fall = -1; n_done = 0;
        for (int k = 1; k <= 50; k++) begin
            cyc(1'b0, 8'h00);
            if (txd == 1'b0 && first_low < 0) first_low = k;
            if (done) begin n_done++; done_at = k; end
            if (!busy && busy_fall < 0 && k > 2) busy_fall = k;
        end
        check("t1_first_low", first_low, 2);
        check("t1_done_at", done_at, 41);
        check("t1_done_count", n_done, 1);
        check("t1_busy_fall", busy_fall, 42);

        // Four back-to-back writes: no full, no overflow, four frames
        do_reset();
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'hFF);
        cyc(1'b1, 8'h00);
        saw_full = 1'b0; n_done = 0;
        for (int k = 0; k < 4 * 41 + 10; k++) begin
            cyc(1'b0, 8'h00);
            if (full) saw_full = 1'b1;
            if (done) n_done++;
        end
        check("t2_full_seen", int'(saw_full), 0);
        check("t2_overflow", int'(ovf), 0);
        check("t2_done_count", n_done, 4);

        // Table vectors: overflow on sixth write
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(vec[i].w, vec[i].d);
            check($sformatf("t3_vec%0d_txd", i), int'(txd), int'(vec[i].txd));
            check($sformatf("t3_vec%0d_busy", i), int'(busy), int'(vec[i].busy));
            check($sformatf("t3_vec%0d_full", i), int'(full), int'(vec[i].full));
            check($sformatf("t3_vec%0d_ovf", i), int'(ovf), int'(vec[i].ovf));
        end
        n_done = 0;
        for (int k = 0; k < 5 * 41 + 20; k++) begin
            cyc(1'b0, 8'h00);
            if (done) n_done++;
        end
        check("t3_frames", n_done, 5);
        check("t3_ovf_sticky", int'(ovf), 1);
        check("t3_idle", int'(busy), 0);

        // Full FIFO, write on the same cycle as the IDLE pop
        do_reset();
        cyc(1'b1, 8'h01);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i));
        check("t4_full", int'(full), 1);
        check("t4_no_ovf_yet", int'(ovf), 0);
        wait_n = 0;
        while (!done && wait_n < 100) begin
            cyc(1'b0, 8'h00);
            wait_n++;
        end
        check("t4_done_seen", int'(done), 1);
        cyc(1'b1, 8'h99);
        check("t4_ovf", int'(ovf), 1);
        check("t4_not_full", int'(full), 0);
        for (int k = 0; k < 4 * 41 + 10; k++) cyc(1'b0, 8'h00);
        check("t4_drained", int'(busy), 0);

        // Reset mid-DATA of 0x81, asynchronous with no clock edge
        do_reset();
        cyc(1'b1, 8'h81);
        for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00);
        check("t5_mid_data_low", int'(txd), 0);
        rst_n = 1'b0;
        #1;
        check("t5_async_txd", int'(txd), 1);
        check("t5_async_busy", int'(busy), 0);
        check("t5_async_full", int'(full), 0);
        check("t5_async_ovf", int'(ovf), 0);
        check("t5_async_done", int'(done), 0);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) cyc(1'b0, 8'h00);

        // Random traffic at two densities against the model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            if (k < 1000) cyc(($urandom_range(0, 39) == 0), 8'($urandom));
            else cyc(($urandom_range(0, 7) == 0), 8'($urandom));
        end
        for (int k = 0; k < 300; k++) cyc(1'b0, 8'h00);

        // Slow instance: 0x4B at 434 clocks per bit
        s_wr   = 1'b1;
        s_data = 8'h4B;
        @(posedge clk); #1;
        s_wr   = 1'b0;
        wait_n = 0;
        while (s_txd !== 1'b0 && wait_n < 10) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("t6_latency", wait_n, 2);
        done_at = -1; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            good = 0;
            for (int c = 0; c < BS; c++) begin
                if (s_txd === frame_bit(8'h4B, i)) good++;
                if (s_done) begin n_done++; done_at = i * BS + c; end
                @(posedge clk); #1;
            end
            check($sformatf("t6_bit%0d_len", i), good, BS);
        end
        check("t6_done_at", done_at, 10 * BS - 1);
        check("t6_done_count", n_done, 1);
        check("t6_idle_txd", int'(s_txd), 1);
        check("t6_idle_busy", int'(s_busy), 0);
        check("t6_full", int'(s_full), 0);
        check("t6_ovf", int'(s_ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
